l1_dcache: RTL and testbench



---
 rtl/l1_dcache_if.sv | 31 +++
 rtl/l1_dcache.sv | 125 ++++++++++++
 tb/tb_l1_dcache.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_if.sv
// CPU-side request/response and burst-level physical-memory signals of the L1 data cache.
// slave is the cache; master is the CPU plus physical memory that surround it.
interface l1_dcache_if #(parameter int LINE_W = 256);
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 0-cycle hits and
// whole-line writeback/fill over a burst physical-memory port.
module l1_dcache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic          clk,
  input  logic          rst,
  l1_dcache_if.slave    bus
);
  localparam int SETS   = 1 << S_INDEX;
  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_W = 8 << S_OFFSET;
  localparam int WSEL_W = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t                state;
  logic [SETS-1:0]       valid, dirty;
  logic [TAG_W-1:0]      tag_arr  [SETS];
  logic [LINE_W-1:0]     data_arr [SETS];
  logic [TAG_W-1:0]      miss_tag;
  logic [S_INDEX-1:0]    miss_idx;

  logic [TAG_W-1:0]      req_tag;
  logic [S_INDEX-1:0]    idx;
  logic [WSEL_W-1:0]     wsel;
  logic [S_OFFSET+2:0]   bit_off;
  logic [LINE_W-1:0]     cur_line, wr_line;
  logic [31:0]           cur_word, merged;
  logic                  req, hit, wr_hit, fill;
  logic                  unused_addr_bits;

  assign req_tag  = bus.mem_address[31 -: TAG_W];
  assign idx      = bus.mem_address[S_OFFSET +: S_INDEX];
  assign wsel     = bus.mem_address[2 +: WSEL_W];
  assign bit_off  = {wsel, 5'd0};
  assign unused_addr_bits = ^bus.mem_address[1:0];

  assign cur_line = data_arr[idx];
  assign cur_word = cur_line[bit_off +: 32];

  assign req    = bus.mem_read | bus.mem_write;
  assign hit    = (state == IDLE) && req && valid[idx] && (tag_arr[idx] == req_tag);
  assign wr_hit = hit && bus.mem_write;
  assign fill   = (state == ALLOCATE) && bus.pmem_resp;

  assign bus.mem_resp  = hit;
  assign bus.mem_rdata = hit ? cur_word : 32'd0;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged[8*b +: 8] = bus.mem_byte_enable[b] ? bus.mem_wdata[8*b +: 8]
                                                     : cur_word[8*b +: 8];
  end

  always_comb begin
    wr_line = cur_line;
    wr_line[bit_off +: 32] = merged;
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[miss_idx] <= bus.pmem_rdata;
      tag_arr[miss_idx]  <= miss_tag;
    end else if (wr_hit) begin
      data_arr[idx] <= wr_line;
    end
  end

  // Miss tag/index are latched so a request dropped mid-miss still fills the right set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      valid            <= '0;
      dirty            <= '0;
      miss_tag         <= '0;
      miss_idx         <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_hit) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            miss_tag <= req_tag;
            miss_idx <= idx;
            if (valid[idx] && dirty[idx]) begin
              state            <= WRITEBACK;
              bus.pmem_write   <= 1'b1;
              bus.pmem_address <= {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
              bus.pmem_wdata   <= cur_line;
            end else begin
              state            <= ALLOCATE;
              bus.pmem_read    <= 1'b1;
              bus.pmem_address <= {req_tag, idx, {S_OFFSET{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state            <= ALLOCATE;
            bus.pmem_write   <= 1'b0;
            bus.pmem_wdata   <= '0;
            bus.pmem_read    <= 1'b1;
            bus.pmem_address <= {miss_tag, miss_idx, {S_OFFSET{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            state            <= IDLE;
            bus.pmem_read    <= 1'b0;
            bus.pmem_address <= '0;
            valid[miss_idx]  <= 1'b1;
            dirty[miss_idx]  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_dcache.sv
// Randomized bench for l1_dcache: CPU-visible memory image plus a per-set tag model
// predicts hits, writebacks, fills, latency and read data.
module tb_l1_dcache;
  localparam int S_INDEX = 3;
  localparam int S_OFFSET = 5;
  localparam int SETS = 8;
  localparam int TAG_W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_dcache_if #(.LINE_W(256)) bus();
  l1_dcache #(.S_INDEX(S_INDEX), .S_OFFSET(S_OFFSET)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;

  logic [255:0] golden  [int unsigned];
  logic [255:0] backing [int unsigned];
  bit               m_valid [SETS];
  bit               m_dirty [SETS];
  logic [TAG_W-1:0] m_tag   [SETS];

  bit           r_wb, r_fill, r_both, r_timeout;
  logic [31:0]  r_wb_addr, r_fill_addr, r_rdata;
  logic [255:0] r_wb_data;
  int           r_lat;

  bit           e_hit, e_wb;
  logic [31:0]  e_wb_addr, e_rd;
  logic [255:0] e_wb_data;

  always @(posedge clk)
    if (!rst) assert (!(bus.mem_read && bus.mem_write)) else $error("illegal read+write request");

  function automatic int unsigned line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic void touch(input int unsigned la);
    logic [255:0] l;
    if (!golden.exists(la)) begin
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      golden[la] = l;
      backing[la] = l;
    end
  endfunction

  // Expectations from the pre-access state, then advance the model.
  function automatic void predict(input logic [31:0] addr, input bit we,
                                  input logic [31:0] wdata, input logic [3:0] be);
    int unsigned la = line_of(addr);
    logic [2:0] idx = addr[7:5];
    logic [TAG_W-1:0] tag = addr[31:8];
    int w = int'(addr[4:2]);
    logic [255:0] line;
    touch(la);
    e_hit = m_valid[idx] && (m_tag[idx] == tag);
    e_wb = !e_hit && m_valid[idx] && m_dirty[idx];
    e_wb_addr = {m_tag[idx], idx, 5'd0};
    e_wb_data = e_wb ? golden[e_wb_addr] : '0;
    if (!e_hit) m_dirty[idx] = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx] = tag;
    line = golden[la];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) line[32*w + 8*b +: 8] = wdata[8*b +: 8];
      golden[la] = line;
      m_dirty[idx] = 1'b1;
    end
    e_rd = line[32*w +: 32];
  endfunction

  // Dirty lines are lost on reset; the CPU-visible image falls back to memory.
  function automatic void model_reset();
    int unsigned la;
    for (int i = 0; i < SETS; i++) begin
      la = {m_tag[i], i[2:0], 5'd0};
      if (m_valid[i] && m_dirty[i]) golden[la] = backing[la];
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                        input logic [3:0] be, input int dw, input int df);
    int pend = 0;
    int cyc = 0;
    r_wb = 0; r_fill = 0; r_both = 0; r_timeout = 0; r_lat = -1; r_rdata = '0;
    @(negedge clk);
    bus.mem_address = addr; bus.mem_read = !we; bus.mem_write = we;
    bus.mem_wdata = wdata; bus.mem_byte_enable = be;
    while (1) begin
      #1;
      if (bus.mem_resp) begin
        r_rdata = bus.mem_rdata; r_lat = cyc; break;
      end
      if (bus.pmem_read && bus.pmem_write) r_both = 1;
      if (bus.pmem_write) begin
        if (pend == 0) begin r_wb = 1; r_wb_addr = bus.pmem_address; r_wb_data = bus.pmem_wdata; end
        pend++;
        if (pend >= dw) begin
          backing[bus.pmem_address] = bus.pmem_wdata; bus.pmem_resp = 1'b1; pend = 0;
        end
      end else if (bus.pmem_read) begin
        if (pend == 0) begin r_fill = 1; r_fill_addr = bus.pmem_address; end
        pend++;
        if (pend >= df) begin
          touch(bus.pmem_address);
          bus.pmem_rdata = backing[bus.pmem_address]; bus.pmem_resp = 1'b1; pend = 0;
        end
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      cyc++;
      if (cyc > 100) begin r_timeout = 1; break; end
    end
    @(posedge clk); #1;
    bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = '0; bus.mem_wdata = '0;
    bus.mem_byte_enable = '0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
    #3;
    n_checks++; if (bus.mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp: got %b want 0", bus.mem_resp); end
    n_checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_pmem_req: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
    n_checks++; if (bus.pmem_address !== 32'd0 || bus.pmem_wdata !== 256'd0) begin n_fail++; $display("FAIL reset_pmem_bus: addr %h want 0", bus.pmem_address); end
    n_checks++; if (bus.mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_miss();
    logic [255:0] l;
    touch(32'h40);
    l = backing[32'h40]; l[31:0] = 32'hDEADBEEF;
    backing[32'h40] = l; golden[32'h40] = l;
    predict(32'h40, 0, 0, 0);
    access(32'h40, 0, 0, 0, 1, 5);
    n_checks++; if (r_fill !== 1'b1 || r_fill_addr !== 32'h40) begin n_fail++; $display("FAIL clean_fill_addr: got %b/%h want 1/00000040", r_fill, r_fill_addr); end
    n_checks++; if (r_wb !== 1'b0) begin n_fail++; $display("FAIL clean_no_wb: got %b want 0", r_wb); end
    n_checks++; if (r_lat !== 6) begin n_fail++; $display("FAIL clean_latency: got %0d want 6", r_lat); end
    n_checks++; if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clean_rdata: got %h want deadbeef", r_rdata); end
    predict(32'h40, 0, 0, 0);
    access(32'h40, 0, 0, 0, 1, 1);
    n_checks++; if (r_lat !== 0 || r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL repeat_hit: lat %0d data %h want 0/deadbeef", r_lat, r_rdata); end
  endtask

  task automatic test_write_hit();
    logic [31:0] old_w = golden[32'h40][63:32];
    logic [31:0] want = {old_w[31:16], 8'hAB, old_w[7:0]};
    predict(32'h44, 1, 32'h0000AB00, 4'b0010);
    access(32'h44, 1, 32'h0000AB00, 4'b0010, 1, 1);
    n_checks++; if (r_lat !== 0 || r_fill !== 1'b0) begin n_fail++; $display("FAIL write_hit_lat: lat %0d fill %b want 0/0", r_lat, r_fill); end
    predict(32'h44, 0, 0, 0);
    access(32'h44, 0, 0, 0, 1, 1);
    n_checks++; if (r_rdata !== want) begin n_fail++; $display("FAIL write_hit_merge: got %h want %h", r_rdata, want); end
  endtask

  task automatic test_dirty_evict();
    predict(32'h1040, 0, 0, 0);
    access(32'h1040, 0, 0, 0, 3, 4);
    n_checks++; if (r_wb !== 1'b1 || r_wb_addr !== 32'h40) begin n_fail++; $display("FAIL evict_wb_addr: got %b/%h want 1/00000040", r_wb, r_wb_addr); end
    n_checks++; if (r_wb_data !== e_wb_data) begin n_fail++; $display("FAIL evict_wb_data: got %h want %h", r_wb_data, e_wb_data); end
    n_checks++; if (r_fill_addr !== 32'h1040) begin n_fail++; $display("FAIL evict_fill_addr: got %h want 00001040", r_fill_addr); end
    n_checks++; if (r_lat !== 8 || r_rdata !== e_rd) begin n_fail++; $display("FAIL evict_resp: lat %0d data %h want 8/%h", r_lat, r_rdata, e_rd); end
    n_checks++; if (r_both !== 1'b0) begin n_fail++; $display("FAIL evict_both_req: got %b want 0", r_both); end
  endtask

  task automatic test_write_miss();
    predict(32'hE0, 1, 32'h12345678, 4'hF);
    access(32'hE0, 1, 32'h12345678, 4'hF, 1, 3);
    n_checks++; if (r_wb !== 1'b0 || r_fill !== 1'b1 || r_lat !== 4) begin n_fail++; $display("FAIL write_miss: wb %b fill %b lat %0d want 0/1/4", r_wb, r_fill, r_lat); end
    predict(32'hE0, 0, 0, 0);
    access(32'hE0, 0, 0, 0, 1, 1);
    n_checks++; if (r_rdata !== 32'h12345678 || r_lat !== 0) begin n_fail++; $display("FAIL write_miss_read: got %h lat %0d want 12345678/0", r_rdata, r_lat); end
  endtask

  task automatic test_zero_mask();
    logic [31:0] old_w;
    predict(32'hA0, 0, 0, 0);
    access(32'hA0, 0, 0, 0, 1, 2);
    old_w = golden[32'hA0][63:32];
    predict(32'hA4, 1, 32'hFFFF_FFFF, 4'b0000);
    access(32'hA4, 1, 32'hFFFF_FFFF, 4'b0000, 1, 1);
    n_checks++; if (r_lat !== 0) begin n_fail++; $display("FAIL zero_mask_resp: lat %0d want 0", r_lat); end
    predict(32'hA4, 0, 0, 0);
    access(32'hA4, 0, 0, 0, 1, 1);
    n_checks++; if (r_rdata !== old_w) begin n_fail++; $display("FAIL zero_mask_data: got %h want %h", r_rdata, old_w); end
    predict(32'h20A0, 0, 0, 0);
    access(32'h20A0, 0, 0, 0, 2, 2);
    n_checks++; if (r_wb !== 1'b1 || r_wb_addr !== 32'hA0) begin n_fail++; $display("FAIL zero_mask_dirty: wb %b addr %h want 1/000000a0", r_wb, r_wb_addr); end
  endtask

  task automatic test_idle_pmem_resp();
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    n_checks++; if ({bus.pmem_read, bus.pmem_write, bus.mem_resp} !== 3'b000) begin n_fail++; $display("FAIL idle_pmem_resp: got %b want 000", {bus.pmem_read, bus.pmem_write, bus.mem_resp}); end
    predict(32'hE0, 0, 0, 0);
    access(32'hE0, 0, 0, 0, 1, 1);
    n_checks++; if (r_lat !== 0 || r_rdata !== e_rd) begin n_fail++; $display("FAIL idle_resp_hit: lat %0d data %h want 0/%h", r_lat, r_rdata, e_rd); end
  endtask

  task automatic test_reset_alloc();
    bit seen = 0;
    touch(32'h60);
    @(negedge clk);
    bus.mem_address = 32'h60; bus.mem_read = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1; if (bus.pmem_read) seen = 1; else @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_alloc_start: pmem_read got 0 want 1"); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'd0) begin n_fail++; $display("FAIL rst_alloc_drop: read %b addr %h want 0/0", bus.pmem_read, bus.pmem_address); end
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    predict(32'h60, 0, 0, 0);
    access(32'h60, 0, 0, 0, 1, 2);
    n_checks++; if (r_fill !== 1'b1 || r_rdata !== e_rd || r_lat !== 3) begin n_fail++; $display("FAIL rst_alloc_refill: fill %b data %h lat %0d want 1/%h/3", r_fill, r_rdata, r_lat, e_rd); end
    predict(32'h44, 0, 0, 0);
    access(32'h44, 0, 0, 0, 1, 2);
    n_checks++; if (r_wb !== 1'b0 || r_rdata !== e_rd) begin n_fail++; $display("FAIL rst_valid_clear: wb %b data %h want 0/%h", r_wb, r_rdata, e_rd); end
  endtask

  task automatic test_back_to_back();
    int good = 0;
    predict(32'h300, 0, 0, 0);
    access(32'h300, 0, 0, 0, 1, 2);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.mem_address = 32'h300 + 4*i; bus.mem_read = 1'b1;
      predict(32'h300 + 4*i, 0, 0, 0);
      #1;
      n_checks++;
      if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== e_rd) begin
        n_fail++; $display("FAIL b2b_word%0d: resp %b data %h want 1/%h", i, bus.mem_resp, bus.mem_rdata, e_rd);
      end else good++;
      @(negedge clk);
    end
    bus.mem_read = 1'b0;
    n_checks++; if (good !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", good); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic [3:0] be;
    bit we;
    int dw, df, lat_want;
    for (int n = 0; n < 150; n++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 2'b00};
      we = 1'($urandom); wd = $urandom; be = 4'($urandom);
      dw = $urandom_range(1, 4); df = $urandom_range(1, 4);
      predict(a, we, wd, be);
      access(a, we, wd, be, dw, df);
      lat_want = e_hit ? 0 : (e_wb ? dw + df + 1 : df + 1);
      n_checks++; if (r_timeout || r_both || r_lat !== lat_want) begin n_fail++; $display("FAIL rnd%0d_lat: lat %0d to %b both %b want %0d", n, r_lat, r_timeout, r_both, lat_want); end
      n_checks++; if (r_wb !== e_wb || r_fill !== !e_hit) begin n_fail++; $display("FAIL rnd%0d_kind: wb %b fill %b want %b/%b", n, r_wb, r_fill, e_wb, !e_hit); end
      if (e_wb) begin
        n_checks++; if (r_wb_addr !== e_wb_addr || r_wb_data !== e_wb_data) begin n_fail++; $display("FAIL rnd%0d_wb: addr %h want %h", n, r_wb_addr, e_wb_addr); end
      end
      if (!e_hit) begin
        n_checks++; if (r_fill_addr !== (a & 32'hFFFF_FFE0)) begin n_fail++; $display("FAIL rnd%0d_fill: addr %h want %h", n, r_fill_addr, a & 32'hFFFF_FFE0); end
      end
      if (!we) begin
        n_checks++; if (r_rdata !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", n, r_rdata, e_rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_zero_mask();
    test_idle_pmem_resp();
    test_reset_alloc();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
